multibyte_add_seq: RTL and testbench

//  Sequences a single 8-bit carry-in adder over NBYTES-wide operands, one byte per clock, LSB first.
//  The carry is chained between cycles, trading throughput for area in the arithmetic path.

---
 rtl/multibyte_add_pkg.sv | 14 +
 rtl/adder8_ci.sv | 12 +
 rtl/multibyte_add_seq.sv | 124 ++++++++++++
 tb/tb_multibyte_add_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/multibyte_add_pkg.sv
// Shared definitions for the byte-serial multi-byte adder.
// Optional subtract mode is enabled by defining MULTIBYTE_ADD_SUB_EN.
package multibyte_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_MAX = 16;

endpackage

// File: rtl/adder8_ci.sv
// Combinational 8-bit adder with carry-in; the only arithmetic in the sequencer.
module adder8_ci (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {8'b0, ci};

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial adder: NBYTES-wide operands summed one byte per clock, LSB first,
// through a single shared adder8_ci with the carry chained in a register.
// Defining MULTIBYTE_ADD_SUB_EN adds a 'sub' input selecting A-B.
module multibyte_add_seq
  import multibyte_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
`ifdef MULTIBYTE_ADD_SUB_EN
  input  logic                    sub,
`endif
  input  logic [8*NBYTES-1:0]     a,
  input  logic [8*NBYTES-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*NBYTES-1:0]     sum,
  output logic                    cout,
  output logic                    busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if (NBYTES < 1 || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
    $error("multibyte_add_seq: NBYTES out of range 1..16");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      a_sh_q, a_sh_d;
  logic [W-1:0]      b_sh_q, b_sh_d;
  logic [W-1:0]      res_q, res_d;
  logic              carry_q, carry_d;

  logic [BYTE_W-1:0] byte_sum;
  logic              byte_co;
  logic [W-1:0]      sum_ext;
  logic [W-1:0]      b_load;
  logic              carry_init;

`ifdef MULTIBYTE_ADD_SUB_EN
  // Subtraction is A + ~B + 1; a final carry of 1 means no borrow.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  adder8_ci u_add (
    .a  (a_sh_q[BYTE_W-1:0]),
    .b  (b_sh_q[BYTE_W-1:0]),
    .ci (carry_q),
    .sum(byte_sum),
    .co (byte_co)
  );

  // Next-state: accept operands in IDLE, consume one byte per RUN edge, hold result in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_ext = '0;
    sum_ext[BYTE_W-1:0] = byte_sum;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = carry_init;
          idx_d   = '0;
        end
      end
      RUN: begin
        // Each sum byte enters at the MSB end so after NBYTES edges byte 0 sits at the LSB.
        res_d   = (res_q >> BYTE_W) | (sum_ext << (W - BYTE_W));
        a_sh_d  = a_sh_q >> BYTE_W;
        b_sh_d  = b_sh_q >> BYTE_W;
        carry_d = byte_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so outputs return to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = res_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq at NBYTES=4 with an expected-result queue.
module tb_multibyte_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sub_s = 1'b0;
  logic [W-1:0] a_s = '0;
  logic [W-1:0] b_s = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum_s;
  logic         cout_s;
  logic         busy_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef MULTIBYTE_ADD_SUB_EN
    .sub      (sub_s),
`endif
    .a        (a_s),
    .b        (b_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum_s),
    .cout     (cout_s),
    .busy     (busy_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    logic [W:0] r;
    logic [W-1:0] yy;
    yy = s ? ~y : y;
    r = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    return r;
  endfunction

  task automatic pop_chk(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 64'(sum_s), 64'(e[W-1:0]));
      chk({tag, "_cout"}, 64'(cout_s), 64'(e[W]));
    end
  endtask

  // Accept one operand pair, measure latency to out_valid, leave result pending.
  task automatic start_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s);
    int n;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a_s = x; b_s = y; sub_s = s; in_valid = 1'b1;
    exp_q.push_back(model(x, y, s));
    tick();
    in_valid = 1'b0;
    a_s = ~x; b_s = ~y;  // post-accept changes must not matter
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(NB));
  endtask

  task automatic finish_op(input string tag);
    pop_chk(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, 64'({in_ready, out_valid, busy_s}), 64'b100);
  endtask

  initial begin
    int cyc, last_acc, nres, nacc;
    logic pend;
    logic [W-1:0] held;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_outputs", 64'({in_ready, out_valid, busy_s, cout_s}), 64'b1000);
    chk("rst_sum", 64'(sum_s), 64'd0);

    // 1: simple add, latency 4
    start_op("t1", 32'h12345678, 32'h11111111, 1'b0);
    finish_op("t1");

    // 2: full carry ripple
    start_op("t2", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    finish_op("t2");

    // 3: hold result with out_ready low; second in_valid is ignored
    start_op("t3", 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0);
    held = sum_s;
    chk("t3_held_val", 64'(held), 64'(32'hA5A5A5A5 + 32'h0F0F0F0F));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a_s = 32'h00000007; b_s = 32'h00000009; in_valid = 1'b1; end
      if (i == 5) in_valid = 1'b0;
      tick();
      chk("t3_hold", 64'({out_valid, in_ready, sum_s}), 64'({1'b1, 1'b0, held}));
    end
    finish_op("t3");
    chk("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // 4: reset on 2nd RUN edge aborts
    a_s = 32'hDEADBEEF; b_s = 32'h01020304; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_abort_ctl", 64'({in_ready, out_valid, busy_s, cout_s}), 64'b1000);
    chk("t4_abort_sum", 64'(sum_s), 64'd0);
    start_op("t4", 32'h00000001, 32'h00000001, 1'b0);
    chk("t4_fresh_val", 64'(sum_s), 64'h2);
    finish_op("t4");

    // 5: back-to-back with both handshakes held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    a_s = 32'h00000100; b_s = 32'h000000FF;
    cyc = 0; last_acc = -1; nres = 0; nacc = 0; pend = 1'b0;
    while (nres < 3 && cyc < 60) begin
      if (pend) begin
        a_s = a_s * 3 + 32'h1357; b_s = b_s ^ 32'hF0F0F0F0;
        pend = 1'b0;
      end
      if (out_valid) begin
        pop_chk("t5");
        nres++;
        if (nres == 3) in_valid = 1'b0;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(model(a_s, b_s, 1'b0));
        if (last_acc >= 0) chk("t5_interval", 64'(cyc - last_acc), 64'd6);
        last_acc = cyc;
        nacc++;
        pend = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("t5_results", 64'(nres), 64'd3);
    chk("t5_accepts", 64'(nacc), 64'd3);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("t5_idle", 64'({in_ready, busy_s}), 64'b10);

`ifdef MULTIBYTE_ADD_SUB_EN
    // 6: subtract mode
    start_op("t6a", 32'h00000000, 32'h00000001, 1'b1);
    finish_op("t6a");
    start_op("t6b", 32'h00000005, 32'h00000003, 1'b1);
    finish_op("t6b");
    sub_s = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
